hs_elastic_fifo: RTL and testbench

- Elastic buffer that sits directly downstream of a dataflow graph output port (the arf dout_N req/ack/data triple) and upstream of a consumer.
- It pulls results from the graph with the graph's req/ack protocol and holds them in a FIFO.
- It serves them to the consumer with the same producer-side protocol, so output rate jitter is decoupled from consumer stalls.
- It also exposes occupancy, transfer counters and a sticky overflow flag for throughput benches.

---
 rtl/hs_elastic_fifo_pkg.sv | 20 ++
 rtl/hs_fifo_mem.sv | 26 ++
 rtl/hs_elastic_fifo.sv | 124 ++++++++++++
 tb/tb_hs_elastic_fifo.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/hs_elastic_fifo_pkg.sv
// Shared constants and helpers for the handshake bench blocks.
package hs_elastic_fifo_pkg;

    localparam int HS_DATA_WIDTH  = 32;
    localparam int HS_COUNT_WIDTH = 32;

    // Ceiling log2, usable in constant expressions; returns 0 for n <= 1.
    function automatic int hs_clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// Register-array storage: one synchronous write port, combinational read.
module hs_fifo_mem #(
    parameter int data_width = 32,
    parameter int depth      = 4,
    parameter int addr_width = 2
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic [addr_width-1:0] waddr_i,
    input  logic [data_width-1:0] wdata_i,
    input  logic [addr_width-1:0] raddr_i,
    output logic [data_width-1:0] rdata_o
);

    logic [data_width-1:0] mem_q [depth];

    // Storage is not reset; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/hs_elastic_fifo.sv
// Elastic buffer between a req/ack graph output port and a req/ack consumer.
// All outputs are registered; the upstream request keeps one slot in reserve
// so an ack arriving a cycle after req drops still has room.
module hs_elastic_fifo
    import hs_elastic_fifo_pkg::*;
#(
    parameter int data_width = HS_DATA_WIDTH,
    parameter int depth      = 4
) (
    input  logic                                 clk,
    input  logic                                 rst,
    output logic                                 up_req,
    input  logic                                 up_ack,
    input  logic [data_width-1:0]                up_din,
    input  logic                                 dn_req,
    output logic                                 dn_ack,
    output logic [data_width-1:0]                dn_dout,
    output logic [hs_clog2(depth):0]             occupancy,
    output logic                                 overflow,
    output logic [HS_COUNT_WIDTH-1:0]            count_in,
    output logic [HS_COUNT_WIDTH-1:0]            count_out
);

    localparam int addr_width = hs_clog2(depth);
    localparam int OCC_W      = addr_width + 1;
    localparam logic [OCC_W-1:0] OCC_FULL    = OCC_W'(depth);
    localparam logic [OCC_W-1:0] OCC_REQ_MAX = OCC_W'(depth - 2);

    logic [addr_width-1:0]     wr_ptr_q, wr_ptr_d;
    logic [addr_width-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]          occ_q, occ_d;
    logic                      up_req_q, up_req_d;
    logic                      dn_ack_q, dn_ack_d;
    logic [data_width-1:0]     dn_dout_q, dn_dout_d;
    logic                      ovf_q, ovf_d;
    logic [HS_COUNT_WIDTH-1:0] cnt_in_q, cnt_in_d;
    logic [HS_COUNT_WIDTH-1:0] cnt_out_q, cnt_out_d;
    logic                      push;
    logic                      pop;
    logic [data_width-1:0]     rd_data;

    hs_fifo_mem #(
        .data_width (data_width),
        .depth      (depth),
        .addr_width (addr_width)
    ) u_mem (
        .clk     (clk),
        .we_i    (push & ~rst),
        .waddr_i (wr_ptr_q),
        .wdata_i (up_din),
        .raddr_i (rd_ptr_q),
        .rdata_o (rd_data)
    );

    // Push/pop decisions and next-state for pointers, occupancy and handshakes.
    always_comb begin
        push      = up_ack && (occ_q < OCC_FULL);
        pop       = dn_req && !dn_ack_q && (occ_q != '0);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        dn_ack_d  = 1'b0;
        dn_dout_d = dn_dout_q;
        ovf_d     = ovf_q;
        cnt_in_d  = cnt_in_q;
        cnt_out_d = cnt_out_q;
        occ_d     = occ_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
            cnt_in_d = cnt_in_q + 1'b1;
        end
        if (up_ack && !push) begin
            ovf_d = 1'b1;
        end
        if (pop) begin
            rd_ptr_d  = rd_ptr_q + 1'b1;
            dn_ack_d  = 1'b1;
            dn_dout_d = rd_data;
            cnt_out_d = cnt_out_q + 1'b1;
        end

        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase

        up_req_d = (occ_d <= OCC_REQ_MAX);
    end

    // State registers with synchronous reset; reset drops all stored words.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            up_req_q  <= 1'b0;
            dn_ack_q  <= 1'b0;
            dn_dout_q <= '0;
            ovf_q     <= 1'b0;
            cnt_in_q  <= '0;
            cnt_out_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            up_req_q  <= up_req_d;
            dn_ack_q  <= dn_ack_d;
            dn_dout_q <= dn_dout_d;
            ovf_q     <= ovf_d;
            cnt_in_q  <= cnt_in_d;
            cnt_out_q <= cnt_out_d;
        end
    end

    assign up_req    = up_req_q;
    assign dn_ack    = dn_ack_q;
    assign dn_dout   = dn_dout_q;
    assign occupancy = occ_q;
    assign overflow  = ovf_q;
    assign count_in  = cnt_in_q;
    assign count_out = cnt_out_q;

endmodule

// File: tb/tb_hs_elastic_fifo.sv
// Scoreboard bench for hs_elastic_fifo (data_width=32, depth=4).
module tb_hs_elastic_fifo;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          up_req;
    logic          up_ack;
    logic [DW-1:0] up_din;
    logic          dn_req;
    logic          dn_ack;
    logic [DW-1:0] dn_dout;
    logic [2:0]    occupancy;
    logic          overflow;
    logic [31:0]   count_in;
    logic [31:0]   count_out;

    hs_elastic_fifo #(.data_width(DW), .depth(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .up_req    (up_req),
        .up_ack    (up_ack),
        .up_din    (up_din),
        .dn_req    (dn_req),
        .dn_ack    (dn_ack),
        .dn_dout   (dn_dout),
        .occupancy (occupancy),
        .overflow  (overflow),
        .count_in  (count_in),
        .count_out (count_out)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;

    // Reference model state
    int          m_occ;
    bit          m_ack, m_req, m_ovf;
    logic [31:0] m_dout, m_cin, m_cout;
    logic [31:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, compare all outputs after the edge.
    task automatic step(input logic ack, input logic [31:0] din, input logic req, input logic r);
        bit push, pop;
        rst    = r;
        up_ack = ack;
        up_din = din;
        dn_req = req;
        push   = !r && ack && (m_occ < DEPTH);
        pop    = !r && req && !m_ack && (m_occ > 0);
        @(posedge clk);
        #1;
        if (r) begin
            m_occ = 0; m_ack = 0; m_req = 0; m_ovf = 0;
            m_dout = '0; m_cin = '0; m_cout = '0;
            sb.delete();
        end else begin
            m_ack = pop;
            if (pop) begin
                m_dout = sb.pop_front();
                m_cout++;
            end
            if (push) begin
                sb.push_back(din);
                m_cin++;
            end
            if (ack && !push) m_ovf = 1;
            m_occ = m_occ + int'(push) - int'(pop);
            m_req = (m_occ <= DEPTH - 2);
        end
        chk("dn_ack", 32'(dn_ack), 32'(m_ack));
        chk("dn_dout", dn_dout, m_dout);
        chk("occupancy", 32'(occupancy), 32'(m_occ));
        chk("up_req", 32'(up_req), 32'(m_req));
        chk("overflow", 32'(overflow), 32'(m_ovf));
        chk("count_in", count_in, m_cin);
        chk("count_out", count_out, m_cout);
    endtask

    task automatic do_reset();
        step(1'b1, 32'd0, 1'b0, 1'b1);
        step(1'b1, 32'd77, 1'b1, 1'b1);
    endtask

    // Drain with dn_req held high; delivered words must be first, first+1, ...
    task automatic drain(input string tag, input int first, input int n_exp, input int cycles);
        int k;
        k = 0;
        for (int i = 0; i < cycles; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b0);
            if (dn_ack) begin
                chk(tag, dn_dout, 32'(first + k));
                k++;
            end
        end
        chk({tag, "_count"}, 32'(k), 32'(n_exp));
    endtask

    initial begin
        int          rcv, nxt, fail_pct, cyc;
        bit          req_prev, req_now, a, dreq;

        rst = 1'b1; up_ack = 1'b0; up_din = '0; dn_req = 1'b0;

        // Reset, then idle
        do_reset();
        chk("rst_up_req", 32'(up_req), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        step(1'b0, 32'd0, 1'b0, 1'b0);
        chk("up_req_rise", 32'(up_req), 32'd1);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b0, 1'b0);

        // Fill with 10, 11, 12 on alternate cycles, no consumer
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'(10 + i), 1'b0, 1'b0);
            if (i < 2) step(1'b0, 32'd0, 1'b0, 1'b0);
        end
        chk("fill_occ", 32'(occupancy), 32'd3);
        chk("fill_up_req", 32'(up_req), 32'd0);
        chk("fill_count_in", count_in, 32'd3);
        chk("fill_ovf", 32'(overflow), 32'd0);

        // Drain them in order
        drain("drain_order", 10, 3, 8);
        chk("drain_count_out", count_out, 32'd3);
        chk("drain_occ", 32'(occupancy), 32'd0);
        chk("drain_up_req", 32'(up_req), 32'd1);

        // Overflow: fill to 4, then a forced ack with 99
        for (int i = 0; i < 4; i++) step(1'b1, 32'(20 + i), 1'b0, 1'b0);
        chk("full_occ", 32'(occupancy), 32'd4);
        step(1'b1, 32'd99, 1'b0, 1'b0);
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_occ", 32'(occupancy), 32'd4);
        drain("ovf_drain", 20, 4, 10);
        chk("ovf_sticky", 32'(overflow), 32'd1);
        do_reset();
        chk("ovf_cleared", 32'(overflow), 32'd0);

        // Simultaneous push and pop at occupancy 2
        step(1'b1, 32'd30, 1'b0, 1'b0);
        step(1'b1, 32'd31, 1'b0, 1'b0);
        step(1'b1, 32'd32, 1'b1, 1'b0);
        chk("simul_occ", 32'(occupancy), 32'd2);
        chk("simul_ack", 32'(dn_ack), 32'd1);
        chk("simul_dout", dn_dout, 32'd30);
        drain("simul_drain", 31, 2, 6);

        // Pointer wrap: 0..8 through a fresh FIFO
        do_reset();
        rcv = 0;
        for (int i = 0; i < 9; i++) begin
            step(1'b1, 32'(i), 1'b1, 1'b0);
            if (dn_ack) begin chk("wrap_seq", dn_dout, 32'(rcv)); rcv++; end
            step(1'b0, 32'd0, 1'b1, 1'b0);
            if (dn_ack) begin chk("wrap_seq", dn_dout, 32'(rcv)); rcv++; end
        end
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 32'd0, 1'b1, 1'b0);
            if (dn_ack) begin chk("wrap_seq", dn_dout, 32'(rcv)); rcv++; end
        end
        chk("wrap_count", 32'(rcv), 32'd9);
        chk("wrap_count_out", count_out, 32'd9);

        // Integration: compliant upstream (ack one cycle after req seen high)
        for (int ph = 0; ph < 2; ph++) begin
            fail_pct = (ph == 0) ? 0 : 50;
            do_reset();
            rcv = 0; nxt = 0; cyc = 0; req_prev = 1'b0;
            while (rcv < 2500 && cyc < 40000) begin
                a       = req_prev && (nxt < 2500) && (int'($urandom_range(99)) >= fail_pct);
                dreq    = (ph == 0) ? 1'b1 : 1'($urandom_range(1));
                req_now = up_req;
                step(a, 32'(nxt), dreq, 1'b0);
                if (a) nxt++;
                req_prev = req_now;
                if (dn_ack) begin
                    chk("integ_seq", dn_dout, 32'(rcv));
                    rcv++;
                end
                cyc++;
            end
            chk("integ_words", 32'(rcv), 32'd2500);
            chk("integ_ovf", 32'(overflow), 32'd0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
